// File: rtl/addsub_accum_if.sv
// Operand/result handshake bundle for addsub_accum_unit.
// The master drives operands and consumes results; the slave is the arithmetic unit.
interface addsub_accum_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cin;
  logic                 add_sub;
  logic                 acc_mode;
  logic                 acc_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 cout;
  logic                 overflow;
  logic                 zero;
  logic [CNT_WIDTH-1:0] op_count;

  modport master (
    output in_valid, a, b, cin, add_sub, acc_mode, acc_clear, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero, op_count
  );

  modport slave (
    input  in_valid, a, b, cin, add_sub, acc_mode, acc_clear, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, op_count
  );
endinterface

// File: rtl/addsub_accum_unit.sv
// Registered add/subtract unit with running accumulator and one-deep output register.
// Optional saturation of overflowing results is enabled by defining ADDSUB_SAT_EN.
module addsub_accum_unit #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  addsub_accum_if.slave bus
);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH:0]       raw;
  logic [WIDTH-1:0]     res_final;
  logic                 ovf;
  logic                 accept;

  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic                 cout_q;
  logic                 overflow_q;
  logic                 zero_q;
  logic [CNT_WIDTH-1:0] op_count_q;

  // A new operand set may enter whenever the output slot is empty or being drained.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    op_a = bus.a;
    if (bus.acc_mode) begin
      op_a = bus.acc_clear ? '0 : acc;
    end
  end

  always_comb begin
    if (bus.add_sub) begin
      raw = {1'b0, op_a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    end else begin
      raw = {1'b0, op_a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
    end
  end

  // Subtraction is treated as adding an operand of opposite sign.
  always_comb begin
    if (bus.add_sub) begin
      ovf = (op_a[WIDTH-1] == bus.b[WIDTH-1]) && (raw[WIDTH-1] != op_a[WIDTH-1]);
    end else begin
      ovf = (op_a[WIDTH-1] != bus.b[WIDTH-1]) && (raw[WIDTH-1] != op_a[WIDTH-1]);
    end
  end

`ifdef ADDSUB_SAT_EN
  // An overflow always moves away from the sign of A, so A's sign picks the rail.
  always_comb begin
    res_final = raw[WIDTH-1:0];
    if (ovf) begin
      res_final = op_a[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  always_comb begin
    res_final = raw[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      op_count_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= res_final;
      cout_q      <= raw[WIDTH];
      overflow_q  <= ovf;
      zero_q      <= (res_final == '0);
      op_count_q  <= op_count_q + CNT_WIDTH'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // An accumulate accept takes priority over a standalone clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept && bus.acc_mode) begin
      acc <= res_final;
    end else if (bus.acc_clear) begin
      acc <= '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.op_count  = op_count_q;

endmodule
